mips_selfcheck_sequencer: RTL and testbench

//  Synthesizable, parametrised stimulus/checker for the single-cycle mips core. Replays a

---
 rtl/mips_selfcheck_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_mips_selfcheck_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_selfcheck_sequencer.sv
// Vector-table replay sequencer for the single-cycle mips core: issues one instruction per
// vector, models data memory on readdata, checks one selected core output per vector.
module mips_selfcheck_sequencer #(
  parameter int DEPTH        = 16,
  parameter int DMEM_AW      = 6,
  parameter int RST_CYCLES   = 2,
  parameter int STOP_ON_FAIL = 0,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int AW = (IW > DMEM_AW) ? IW : DMEM_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] num_vec,
  input  logic          ld_we,
  input  logic          ld_dmem,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  input  logic [31:0]   ld_expect,
  input  logic [1:0]    ld_sel,
  output logic          dut_reset,
  output logic [31:0]   instr,
  input  logic [31:0]   pc,
  input  logic          memwrite,
  input  logic [31:0]   aluout,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] pass_count,
  output logic [CW-1:0] fail_count,
  output logic [IW-1:0] first_fail
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_ISSUE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e        state_r, state_n;
  logic [IW-1:0] idx_r, idx_n;
  logic [RW-1:0] rcnt_r, rcnt_n;
  logic [CW-1:0] nvec_r, nvec_n;
  logic [CW-1:0] pcnt_r, pcnt_n;
  logic [CW-1:0] fcnt_r, fcnt_n;
  logic [IW-1:0] ff_r, ff_n;
  logic          done_r, done_n;
  logic          pass_r, pass_n;
  logic          busy_r, busy_n;
  logic          dut_reset_r, dut_reset_n;
  logic [31:0]   instr_r, instr_n;
  logic [31:0]   cap_alu_r;
  logic [31:0]   cap_wd_r;
  logic          match_s;
  logic          last_s;

  logic [31:0] tbl_instr_r  [DEPTH];
  logic [31:0] tbl_expect_r [DEPTH];
  logic [1:0]  tbl_sel_r    [DEPTH];
  logic [31:0] dmem_r       [2**DMEM_AW];

  logic               tbl_we_s;
  logic               dm_ld_we_s;
  logic               core_we_s;
  logic               in_range_s;
  logic [DMEM_AW-1:0] dm_idx_s;
  logic [CW-1:0]      nvec_clamp_s;
  logic               unused_ok_s;

  // Core addresses are word aligned; the byte-offset bits carry no information here.
  assign unused_ok_s  = &{1'b0, aluout[1:0]};
  assign in_range_s   = (aluout[31:DMEM_AW+2] == {(30-DMEM_AW){1'b0}});
  assign dm_idx_s     = aluout[DMEM_AW+1:2];
  assign readdata     = in_range_s ? dmem_r[dm_idx_s] : 32'd0;
  assign tbl_we_s     = ld_we && !busy_r && !ld_dmem && (32'(ld_addr) < DEPTH_U);
  assign dm_ld_we_s   = ld_we && !busy_r && ld_dmem;
  assign core_we_s    = (state_r == S_ISSUE) && memwrite && in_range_s;
  assign nvec_clamp_s = (32'(num_vec) > DEPTH_U) ? CW'(DEPTH) : num_vec;
  assign last_s       = ((CW'(idx_r) + CW'(1'b1)) == nvec_r);

  assign dut_reset  = dut_reset_r;
  assign instr      = instr_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign pass_count = pcnt_r;
  assign fail_count = fcnt_r;
  assign first_fail = ff_r;

  // Vector table write port (contents survive reset)
  always_ff @(posedge clk) begin
    if (tbl_we_s) begin
      tbl_instr_r[ld_addr[IW-1:0]]  <= ld_data;
      tbl_expect_r[ld_addr[IW-1:0]] <= ld_expect;
      tbl_sel_r[ld_addr[IW-1:0]]    <= ld_sel;
    end
  end

  // Data memory: core stores during a run, loader writes while idle
  always_ff @(posedge clk) begin
    if (core_we_s) begin
      dmem_r[dm_idx_s] <= writedata;
    end else if (dm_ld_we_s) begin
      dmem_r[ld_addr[DMEM_AW-1:0]] <= ld_data;
    end
  end

  // Compare the selected field; aluout/writedata come from the ISSUE-cycle capture
  always_comb begin
    match_s = 1'b1;
    case (tbl_sel_r[idx_r])
      2'd0:    match_s = 1'b1;
      2'd1:    match_s = (cap_alu_r == tbl_expect_r[idx_r]);
      2'd2:    match_s = (cap_wd_r == tbl_expect_r[idx_r]);
      2'd3:    match_s = (pc == tbl_expect_r[idx_r]);
      default: match_s = 1'b1;
    endcase
  end

  // Next-state, result updates and next-cycle output values
  always_comb begin
    state_n = state_r;
    idx_n   = idx_r;
    rcnt_n  = rcnt_r;
    nvec_n  = nvec_r;
    pcnt_n  = pcnt_r;
    fcnt_n  = fcnt_r;
    ff_n    = ff_r;
    done_n  = done_r;
    pass_n  = pass_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_RST;
          idx_n   = {IW{1'b0}};
          rcnt_n  = {RW{1'b0}};
          nvec_n  = nvec_clamp_s;
          pcnt_n  = {CW{1'b0}};
          fcnt_n  = {CW{1'b0}};
          ff_n    = {IW{1'b0}};
          done_n  = 1'b0;
          pass_n  = 1'b0;
        end else begin
          state_n = state_r;
        end
      end
      S_RST: begin
        if (rcnt_r == RW'(RST_CYCLES - 1)) begin
          if (nvec_r == {CW{1'b0}}) begin
            state_n = S_DONE;
            done_n  = 1'b1;
            pass_n  = 1'b1;
          end else begin
            state_n = S_ISSUE;
          end
        end else begin
          rcnt_n = rcnt_r + RW'(1'b1);
        end
      end
      S_ISSUE: state_n = S_CHECK;
      S_CHECK: begin
        if (match_s) begin
          pcnt_n = pcnt_r + CW'(1'b1);
        end else begin
          fcnt_n = fcnt_r + CW'(1'b1);
          if (fcnt_r == {CW{1'b0}}) begin
            ff_n = idx_r;
          end else begin
            ff_n = ff_r;
          end
        end
        if (last_s || (!match_s && (STOP_ON_FAIL != 0))) begin
          state_n = S_DONE;
          done_n  = 1'b1;
          pass_n  = (fcnt_n == {CW{1'b0}});
        end else begin
          state_n = S_ISSUE;
          idx_n   = idx_r + IW'(1'b1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    busy_n      = (state_n == S_RST) || (state_n == S_ISSUE) || (state_n == S_CHECK);
    dut_reset_n = !((state_n == S_ISSUE) || (state_n == S_CHECK));
    if (state_n == S_ISSUE) begin
      instr_n = tbl_instr_r[idx_n];
    end else begin
      instr_n = 32'd0;
    end
  end

  // State, result and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      idx_r       <= {IW{1'b0}};
      rcnt_r      <= {RW{1'b0}};
      nvec_r      <= {CW{1'b0}};
      pcnt_r      <= {CW{1'b0}};
      fcnt_r      <= {CW{1'b0}};
      ff_r        <= {IW{1'b0}};
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      busy_r      <= 1'b0;
      dut_reset_r <= 1'b1;
      instr_r     <= 32'd0;
      cap_alu_r   <= 32'd0;
      cap_wd_r    <= 32'd0;
    end else begin
      state_r     <= state_n;
      idx_r       <= idx_n;
      rcnt_r      <= rcnt_n;
      nvec_r      <= nvec_n;
      pcnt_r      <= pcnt_n;
      fcnt_r      <= fcnt_n;
      ff_r        <= ff_n;
      done_r      <= done_n;
      pass_r      <= pass_n;
      busy_r      <= busy_n;
      dut_reset_r <= dut_reset_n;
      instr_r     <= instr_n;
      if (state_r == S_ISSUE) begin
        cap_alu_r <= aluout;
        cap_wd_r  <= writedata;
      end
    end
  end

endmodule

// File: tb/tb_mips_selfcheck_sequencer.sv
// Directed bench for mips_selfcheck_sequencer with a tiny behavioural mips core
// (ADDI/LW/SW/BEQ/NOP) driving pc/aluout/memwrite/writedata.
module tb_mips_selfcheck_sequencer;
  logic        clk = 1'b0;
  logic        reset, start, start2, ld_we, ld_we2, ld_dmem;
  logic [4:0]  num_vec;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data, ld_expect;
  logic [1:0]  ld_sel;

  logic        dut_reset, busy, done, pass;
  logic [31:0] instr, readdata;
  logic [4:0]  pass_count, fail_count;
  logic [3:0]  first_fail;

  logic        dut_reset2_unused, busy2, done2, pass2;
  logic [31:0] instr2_unused, readdata2_unused;
  logic [4:0]  pass_count2, fail_count2;
  logic [3:0]  first_fail2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0 = 0;
  int lat;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-cycle core
  logic [31:0] rf [32];
  logic [31:0] cpc, c_alu, c_wd, c_a, c_b, c_imm;
  logic [5:0]  c_op;
  logic        c_mw;

  always_comb begin
    c_op  = instr[31:26];
    c_a   = rf[instr[25:21]];
    c_b   = rf[instr[20:16]];
    c_imm = {{16{instr[15]}}, instr[15:0]};
    case (c_op)
      6'h08, 6'h23, 6'h2b: c_alu = c_a + c_imm;
      6'h04:               c_alu = c_a - c_b;
      default:             c_alu = 32'd0;
    endcase
    c_mw = (c_op == 6'h2b) && !dut_reset;
    c_wd = c_b;
  end

  always @(posedge clk) begin
    if (dut_reset) begin
      cpc <= 32'd0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      cpc <= (c_op == 6'h04 && c_a == c_b) ? cpc + 32'd4 + (c_imm << 2) : cpc + 32'd4;
      if (c_op == 6'h08 && instr[20:16] != 5'd0) rf[instr[20:16]] <= c_alu;
      if (c_op == 6'h23 && instr[20:16] != 5'd0) rf[instr[20:16]] <= readdata;
    end
  end

  mips_selfcheck_sequencer #(.DEPTH(16), .DMEM_AW(6), .RST_CYCLES(2), .STOP_ON_FAIL(0)) dut (
    .clk(clk), .reset(reset), .start(start), .num_vec(num_vec), .ld_we(ld_we),
    .ld_dmem(ld_dmem), .ld_addr(ld_addr), .ld_data(ld_data), .ld_expect(ld_expect),
    .ld_sel(ld_sel), .dut_reset(dut_reset), .instr(instr), .pc(cpc), .memwrite(c_mw),
    .aluout(c_alu), .writedata(c_wd), .readdata(readdata), .busy(busy), .done(done),
    .pass(pass), .pass_count(pass_count), .fail_count(fail_count), .first_fail(first_fail)
  );

  mips_selfcheck_sequencer #(.DEPTH(16), .DMEM_AW(6), .RST_CYCLES(2), .STOP_ON_FAIL(1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .num_vec(num_vec), .ld_we(ld_we2),
    .ld_dmem(ld_dmem), .ld_addr(ld_addr), .ld_data(ld_data), .ld_expect(ld_expect),
    .ld_sel(ld_sel), .dut_reset(dut_reset2_unused), .instr(instr2_unused), .pc(32'd0),
    .memwrite(1'b0), .aluout(32'd0), .writedata(32'd0), .readdata(readdata2_unused),
    .busy(busy2), .done(done2), .pass(pass2), .pass_count(pass_count2),
    .fail_count(fail_count2), .first_fail(first_fail2)
  );

  task automatic load_vec(input logic to2, input int i, input logic [31:0] ins,
                          input logic [31:0] exp, input logic [1:0] s);
    ld_addr = 6'(i); ld_data = ins; ld_expect = exp; ld_sel = s; ld_dmem = 1'b0;
    if (to2) ld_we2 = 1'b1; else ld_we = 1'b1;
    @(negedge clk);
    ld_we = 1'b0; ld_we2 = 1'b0;
  endtask

  task automatic load_dmem(input int a, input logic [31:0] d);
    ld_addr = 6'(a); ld_data = d; ld_dmem = 1'b1; ld_we = 1'b1;
    @(negedge clk);
    ld_we = 1'b0; ld_dmem = 1'b0;
  endtask

  task automatic start_run(input logic [4:0] n);
    num_vec = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0; t0 = cyc;
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (done !== 1'b1 && k < bound) begin
      @(negedge clk);
      k++;
    end
    lat = cyc - t0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start2 = 1'b0; ld_we = 1'b0; ld_we2 = 1'b0; ld_dmem = 1'b0;
    num_vec = 5'd0; ld_addr = 6'd0; ld_data = 32'd0; ld_expect = 32'd0; ld_sel = 2'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (dut_reset !== 1'b1) begin errors++; $display("FAIL reset_dut_reset got=%0b exp=1", dut_reset); end
    checks++; if (instr !== 32'd0) begin errors++; $display("FAIL reset_instr got=%h exp=0", instr); end
    checks++; if ({busy, done, pass} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {busy, done, pass}); end
    checks++; if ({pass_count, fail_count, first_fail} !== 14'd0) begin errors++; $display("FAIL reset_counts got=%h exp=0", {pass_count, fail_count, first_fail}); end
  endtask

  task automatic test_single();
    load_vec(1'b0, 0, 32'h20010005, 32'd5, 2'd1);
    start_run(5'd1);
    checks++; if ({busy, dut_reset} !== 2'b11) begin errors++; $display("FAIL single_rst got=%b exp=11", {busy, dut_reset}); end
    repeat (2) @(negedge clk);
    checks++; if (instr !== 32'h20010005 || dut_reset !== 1'b0) begin errors++; $display("FAIL single_issue instr=%h rst=%0b exp=20010005/0", instr, dut_reset); end
    @(negedge clk);
    checks++; if (instr !== 32'd0 || done !== 1'b0) begin errors++; $display("FAIL single_check instr=%h done=%0b exp=0/0", instr, done); end
    @(negedge clk);
    checks++; if ({done, pass, busy, dut_reset} !== 4'b1101) begin errors++; $display("FAIL single_done got=%b exp=1101", {done, pass, busy, dut_reset}); end
    checks++; if (pass_count !== 5'd1 || fail_count !== 5'd0) begin errors++; $display("FAIL single_counts got=%0d/%0d exp=1/0", pass_count, fail_count); end
  endtask

  task automatic test_dmem();
    load_vec(1'b0, 0, 32'h20010005, 32'd5, 2'd1);
    load_vec(1'b0, 1, 32'hAC010004, 32'd5, 2'd2);
    load_vec(1'b0, 2, 32'h8C060004, 32'd4, 2'd1);
    start_run(5'd3);
    repeat (6) @(negedge clk);
    checks++; if (instr !== 32'h8C060004 || readdata !== 32'd5) begin errors++; $display("FAIL dmem_lw instr=%h rd=%h exp=8c060004/5", instr, readdata); end
    wait_done(20);
    checks++; if (done !== 1'b1 || lat !== 8) begin errors++; $display("FAIL dmem_latency done=%0b lat=%0d exp=1/8", done, lat); end
    checks++; if (pass_count !== 5'd3 || pass !== 1'b1) begin errors++; $display("FAIL dmem_counts got=%0d pass=%0b exp=3/1", pass_count, pass); end
  endtask

  task automatic test_branch();
    load_vec(1'b0, 0, 32'h20070005, 32'd5, 2'd1);
    load_vec(1'b0, 1, 32'h20080005, 32'd5, 2'd1);
    load_vec(1'b0, 2, 32'h10E80002, 32'd28, 2'd3);
    start_run(5'd3);
    wait_done(20);
    checks++; if (lat !== 8 || pass_count !== 5'd3 || pass !== 1'b1) begin errors++; $display("FAIL branch_pass lat=%0d pc=%0d pass=%0b exp=8/3/1", lat, pass_count, pass); end
    load_vec(1'b0, 2, 32'h10E80002, 32'd20, 2'd3);
    start_run(5'd3);
    wait_done(20);
    checks++; if (fail_count !== 5'd1 || pass_count !== 5'd2) begin errors++; $display("FAIL branch_fail counts got=%0d/%0d exp=2/1", pass_count, fail_count); end
    checks++; if (first_fail !== 4'd2 || pass !== 1'b0) begin errors++; $display("FAIL branch_first got=%0d pass=%0b exp=2/0", first_fail, pass); end
  endtask

  task automatic test_out_of_range();
    load_dmem(0, 32'h00001234);
    load_vec(1'b0, 0, 32'h20010005, 32'd5, 2'd1);
    load_vec(1'b0, 1, 32'h20020100, 32'h100, 2'd1);
    load_vec(1'b0, 2, 32'hAC410000, 32'd5, 2'd2);
    load_vec(1'b0, 3, 32'h8C030000, 32'd0, 2'd0);
    load_vec(1'b0, 4, 32'h8C040100, 32'h100, 2'd1);
    start_run(5'd5);
    repeat (8) @(negedge clk);
    checks++; if (instr !== 32'h8C030000 || readdata !== 32'h1234) begin errors++; $display("FAIL oor_store_dropped instr=%h rd=%h exp=8c030000/1234", instr, readdata); end
    repeat (2) @(negedge clk);
    checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL oor_read got=%h exp=0", readdata); end
    wait_done(20);
    checks++; if (lat !== 12 || pass_count !== 5'd5) begin errors++; $display("FAIL oor_done lat=%0d pc=%0d exp=12/5", lat, pass_count); end
  endtask

  task automatic test_num_vec();
    start_run(5'd0);
    wait_done(10);
    checks++; if (lat !== 2 || pass !== 1'b1 || pass_count !== 5'd0 || fail_count !== 5'd0) begin errors++; $display("FAIL numvec0 lat=%0d pass=%0b cnt=%0d/%0d exp=2/1/0/0", lat, pass, pass_count, fail_count); end
    for (int i = 0; i < 16; i++) load_vec(1'b0, i, 32'h20010005, 32'd5, 2'd1);
    start_run(5'd19);
    wait_done(60);
    checks++; if (lat !== 34 || pass_count !== 5'd16 || fail_count !== 5'd0) begin errors++; $display("FAIL numvec_clamp lat=%0d cnt=%0d/%0d exp=34/16/0", lat, pass_count, fail_count); end
  endtask

  task automatic test_busy_ignore();
    start_run(5'd2);
    load_vec(1'b0, 1, 32'h20010005, 32'd99, 2'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(20);
    checks++; if (lat !== 6 || pass_count !== 5'd2 || fail_count !== 5'd0) begin errors++; $display("FAIL busy_ignore lat=%0d cnt=%0d/%0d exp=6/2/0", lat, pass_count, fail_count); end
  endtask

  task automatic test_reset_midrun();
    start_run(5'd2);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({busy, done, dut_reset} !== 3'b001 || instr !== 32'd0) begin errors++; $display("FAIL midrun_flags got=%b instr=%h exp=001/0", {busy, done, dut_reset}, instr); end
    checks++; if (pass_count !== 5'd0 || fail_count !== 5'd0) begin errors++; $display("FAIL midrun_counts got=%0d/%0d exp=0/0", pass_count, fail_count); end
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrun_idle busy=%0b done=%0b exp=0/0", busy, done); end
  endtask

  task automatic test_stop_on_fail();
    load_vec(1'b1, 0, 32'd0, 32'd0, 2'd1);
    load_vec(1'b1, 1, 32'd0, 32'd1, 2'd1);
    load_vec(1'b1, 2, 32'd0, 32'd0, 2'd1);
    load_vec(1'b1, 3, 32'd0, 32'd0, 2'd1);
    num_vec = 5'd4; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL stop_early got=%0b exp=0", done2); end
    @(negedge clk);
    checks++; if (done2 !== 1'b1 || busy2 !== 1'b0 || pass2 !== 1'b0) begin errors++; $display("FAIL stop_done got=%b exp=100", {done2, busy2, pass2}); end
    checks++; if (fail_count2 !== 5'd1 || pass_count2 !== 5'd1 || first_fail2 !== 4'd1) begin errors++; $display("FAIL stop_counts got=%0d/%0d ff=%0d exp=1/1/1", pass_count2, fail_count2, first_fail2); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dmem();
    test_branch();
    test_out_of_range();
    test_num_vec();
    test_busy_ignore();
    test_reset_midrun();
    test_stop_on_fail();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
